// File: rtl/rd_seq_pkg.sv
// Shared types and default sizing for the read-request sequencer.
package rd_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ERR
    } seq_state_e;

    localparam int DEF_DEPTH = 4;
    localparam int DEF_LEN_W = 4;
    localparam int DEF_TMO   = 64;

endpackage

// File: rtl/rd_req_fifo.sv
// Synchronous request FIFO holding burst lengths; flush empties it in one cycle.
module rd_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers and count
    // guarantee stale entries are never read.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rd_req_sequencer.sv
// Command stage: queues burst requests, issues one go per beat, counts ds, watchdog.
module rd_req_sequencer
    import rd_seq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int LEN_W = DEF_LEN_W,
    parameter int TMO   = DEF_TMO
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    input  logic [LEN_W-1:0]         req_len,
    output logic                     req_ready,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     go,
    input  logic                     ds,
    output logic                     busy,
    output logic [LEN_W-1:0]         beats_left,
    output logic                     done_pulse,
    output logic                     tmo_err,
    input  logic                     clr_err
);

    localparam int              WD_W   = $clog2(TMO);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TMO - 1);

    seq_state_e       state, state_d;
    logic [LEN_W-1:0] beats_d;
    logic [WD_W-1:0]  wdog, wdog_d;
    logic             tmo_d;
    logic             done_d;
    logic             fifo_pop;
    logic             fifo_flush;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LEN_W-1:0] fifo_head;

    // Ready derives only from registered state so a same-cycle pop never frees a slot.
    assign req_ready = !fifo_full && (state != S_ERR);

    rd_req_fifo #(
        .DEPTH (DEPTH),
        .W     (LEN_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_valid && req_ready),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (req_len),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        state_d    = state;
        beats_d    = beats_left;
        wdog_d     = wdog;
        tmo_d      = tmo_err;
        done_d     = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    beats_d  = fifo_head;
                    if (fifo_head != '0) state_d = S_ISSUE;
                    else                 done_d  = 1'b1;
                end
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A ds on the expiry cycle still counts the beat.
                if (ds) begin
                    if (beats_left != '0) beats_d = beats_left - 1'b1;
                    if (beats_left <= LEN_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else if (wdog == WD_MAX) begin
                    tmo_d      = 1'b1;
                    fifo_flush = 1'b1;
                    state_d    = S_ERR;
                end else begin
                    wdog_d = wdog + 1'b1;
                end
            end
            S_ERR: begin
                if (clr_err) begin
                    tmo_d   = 1'b0;
                    beats_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state so go/busy line up with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_left <= '0;
            wdog       <= '0;
            tmo_err    <= 1'b0;
            done_pulse <= 1'b0;
            go         <= 1'b0;
            busy       <= 1'b0;
        end else begin
            beats_left <= beats_d;
            wdog       <= wdog_d;
            tmo_err    <= tmo_d;
            done_pulse <= done_d;
            go         <= (state_d == S_ISSUE);
            busy       <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_rd_req_sequencer.sv
// Directed bench for rd_req_sequencer with a queue-based go/done scoreboard.
module tb_rd_req_sequencer;

    localparam int DEPTH = 4;
    localparam int LEN_W = 4;
    localparam int TMO   = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic [LEN_W-1:0] req_len;
    logic             req_ready;
    logic [2:0]       fifo_cnt;
    logic             go;
    logic             ds;
    logic             ds_man;
    logic             ds_resp;
    logic             busy;
    logic [LEN_W-1:0] beats_left;
    logic             done_pulse;
    logic             tmo_err;
    logic             clr_err;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;
    int resp_cd  = 0;
    bit resp_en  = 1'b0;

    int go_exp[$];
    int done_exp[$];

    assign ds = ds_man | ds_resp;

    always #5 clk = ~clk;

    rd_req_sequencer #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W),
        .TMO   (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_len    (req_len),
        .req_ready  (req_ready),
        .fifo_cnt   (fifo_cnt),
        .go         (go),
        .ds         (ds),
        .busy       (busy),
        .beats_left (beats_left),
        .done_pulse (done_pulse),
        .tmo_err    (tmo_err),
        .clr_err    (clr_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Auto responder: ds high during the second cycle after each go.
    always @(negedge clk) begin
        ds_resp = 1'b0;
        if (resp_cd > 0) begin
            resp_cd--;
            if (resp_cd == 0) ds_resp = 1'b1;
        end
        if (resp_en && go) resp_cd = 2;
    end

    // Scoreboard monitor: each go/done_pulse consumes one expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (go) begin
                if (go_exp.size() == 0) check("go_unexpected", go, 0);
                else                    check("go_beats_left", beats_left, go_exp.pop_front());
            end
            if (done_pulse) begin
                done_seen++;
                check("done_busy", busy, 0);
                if (done_exp.size() == 0) check("done_unexpected", done_pulse, 0);
                else                      check("done_beats_left", beats_left, done_exp.pop_front());
            end
        end
    end

    task automatic push_req(input int len);
        req_valid = 1'b1;
        req_len   = LEN_W'(len);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int start = done_seen;
        int n = 0;
        while (done_seen == start && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, done_seen - start, 1);
    endtask

    initial begin
        int lens [5] = '{2, 5, 6, 7, 9};
        int n;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_len   = '0;
        ds_man    = 1'b0;
        ds_resp   = 1'b0;
        clr_err   = 1'b0;
        #1;
        check("rst_go", go, 0);
        check("rst_done", done_pulse, 0);
        check("rst_tmo", tmo_err, 0);
        check("rst_busy", busy, 0);
        check("rst_beats", beats_left, 0);
        check("rst_cnt", fifo_cnt, 0);
        check("rst_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single len=3 burst, ds two cycles after each go.
        resp_en = 1'b1;
        go_exp.push_back(3); go_exp.push_back(2); go_exp.push_back(1);
        done_exp.push_back(0);
        push_req(3);
        wait_done("t1_done_seen");
        @(negedge clk);
        check("t1_beats_end", beats_left, 0);
        check("t1_busy_end", busy, 0);
        resp_en = 1'b0;
        repeat (4) @(negedge clk);

        // Fill FIFO while a len=1 burst sits in WAIT.
        go_exp.push_back(1);
        push_req(1);
        repeat (2) @(negedge clk);
        check("t2_busy_wait", busy, 1);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_len   = LEN_W'(lens[i]);
            check("t2_ready", req_ready, (i < 4) ? 1 : 0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("t2_cnt_full", fifo_cnt, 4);
        check("t2_ready_full", req_ready, 0);
        done_exp.push_back(0);
        go_exp.push_back(2);
        ds_man = 1'b1;
        @(negedge clk);
        ds_man = 1'b0;
        @(negedge clk);
        check("t2_cnt_after_pop", fifo_cnt, 3);
        check("t2_go_len2", go, 1);

        // Timeout on the len=2 burst.
        n = 0;
        while (!tmo_err && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t3_tmo_latency", n, TMO + 1);
        check("t3_cnt_flushed", fifo_cnt, 0);
        check("t3_ready_err", req_ready, 0);
        check("t3_go_err", go, 0);
        check("t3_busy_err", busy, 1);
        check("t3_beats_err", beats_left, 2);
        ds_man = 1'b1;
        @(negedge clk);
        ds_man = 1'b0;
        repeat (2) @(negedge clk);
        check("t3_tmo_sticky", tmo_err, 1);
        check("t3_ds_ignored", beats_left, 2);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("t3_tmo_clr", tmo_err, 0);
        check("t3_busy_clr", busy, 0);
        check("t3_beats_clr", beats_left, 0);
        check("t3_ready_clr", req_ready, 1);
        @(negedge clk);

        // Zero-length request: done two cycles after accept, never busy.
        done_exp.push_back(0);
        req_valid = 1'b1;
        req_len   = '0;
        @(negedge clk);
        req_valid = 1'b0;
        check("t4_done_early", done_pulse, 0);
        check("t4_busy1", busy, 0);
        @(negedge clk);
        check("t4_done", done_pulse, 1);
        check("t4_busy2", busy, 0);
        @(negedge clk);
        check("t4_done_one_cycle", done_pulse, 0);
        repeat (2) @(negedge clk);

        // Async reset in WAIT with two entries queued.
        go_exp.push_back(4);
        push_req(4);
        push_req(1);
        push_req(1);
        check("t5_cnt_queued", fifo_cnt, 2);
        check("t5_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_go", go, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_beats", beats_left, 0);
        check("t5_rst_cnt", fifo_cnt, 0);
        check("t5_rst_ready", req_ready, 1);
        check("t5_rst_tmo", tmo_err, 0);
        check("t5_rst_done", done_pulse, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_post_busy", busy, 0);
        check("t5_post_cnt", fifo_cnt, 0);

        // ds in IDLE is ignored.
        ds_man = 1'b1;
        @(negedge clk);
        ds_man = 1'b0;
        check("t6_idle_beats", beats_left, 0);
        check("t6_idle_busy", busy, 0);
        check("t6_idle_done", done_pulse, 0);

        // ds on the exact expiry cycle wins over the watchdog.
        go_exp.push_back(1);
        done_exp.push_back(0);
        push_req(1);
        @(negedge clk);
        check("t6_go", go, 1);
        repeat (TMO) @(negedge clk);
        check("t6_no_tmo_yet", tmo_err, 0);
        ds_man = 1'b1;
        @(negedge clk);
        ds_man = 1'b0;
        check("t6_done_expiry", done_pulse, 1);
        check("t6_tmo_expiry", tmo_err, 0);
        check("t6_busy_expiry", busy, 0);
        repeat (3) @(negedge clk);
        check("t6_tmo_after", tmo_err, 0);

        check("sb_go_left", go_exp.size(), 0);
        check("sb_done_left", done_exp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
